// File: rtl/eth_tx_pkg.sv
// Shared types and helpers for the Ethernet TX frame sequencer.
package eth_tx_pkg;

    typedef enum logic [1:0] {StIdle, StSeg, StPad, StGap} tx_seq_state_t;

    localparam int unsigned ETH_MIN_LEN   = 60;
    localparam int unsigned ETH_IFG_BYTES = 12;
    localparam int unsigned MAX_SEG       = 8;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } seg_sel_t;

    // Lowest set bit of mask strictly above idx (idx = -1 searches the whole mask).
    function automatic seg_sel_t next_seg(input logic [MAX_SEG-1:0] mask, input int idx);
        seg_sel_t sel;
        sel = '0;
        for (int i = MAX_SEG - 1; i >= 0; i--) begin
            if (mask[i] && (i > idx)) begin
                sel.valid = 1'b1;
                sel.idx   = 3'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/eth_tx_frame_seq.sv
// Sequences enabled frame segments onto one beat stream, with min-length padding before
// the FCS segment, abort handling and a programmable inter-frame gap.
module eth_tx_frame_seq
    import eth_tx_pkg::*;
#(
    parameter int unsigned NUM_SEG       = 4,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned PAD_SEG       = 3,
    parameter int unsigned LEN_FIRST_SEG = 1,
    parameter int unsigned MIN_LEN       = ETH_MIN_LEN,
    parameter int unsigned IFG_CYCLES    = ETH_IFG_BYTES
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      frame_start,
    input  logic [NUM_SEG-1:0]        seg_en,
    input  logic [NUM_SEG-1:0]        seg_done,
    input  logic [NUM_SEG*DATA_W-1:0] seg_data,
    input  logic                      abort,
    output logic [NUM_SEG-1:0]        seg_active,
    output logic                      pad_active,
    output logic                      data_valid,
    output logic [DATA_W-1:0]         data_out,
    output logic                      busy,
    output logic                      tx_frame_done,
    output logic                      tx_frame_aborted,
    output logic [15:0]               frame_len
);

    localparam int unsigned SegW = $clog2(NUM_SEG);
    localparam int unsigned BPB  = DATA_W / 8;

    localparam logic [SegW-1:0] LenFirstIdx = SegW'(LEN_FIRST_SEG);
    localparam logic [SegW-1:0] PadIdx      = SegW'(PAD_SEG);
    localparam logic [2:0]      PadIdx3     = 3'(PAD_SEG);
    localparam logic [15:0]     MinLen      = 16'(MIN_LEN);
    localparam logic [15:0]     IfgLast     = 16'(IFG_CYCLES - 1);

    tx_seq_state_t     state_q, state_d;
    logic [SegW-1:0]   seg_idx_q, seg_idx_d;
    logic [NUM_SEG-1:0] en_q, en_d;
    logic [15:0]       len_cnt_q, len_cnt_d;
    logic [15:0]       gap_cnt_q, gap_cnt_d;
    logic [15:0]       frame_len_q, frame_len_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    logic [16:0]        len_sum;
    logic [15:0]        len_sat;
    logic [15:0]        len_post;
    logic [MAX_SEG-1:0] sel_mask;
    int                 sel_from;
    seg_sel_t           nxt;

    assign len_sum = {1'b0, len_cnt_q} + 17'(BPB);
    assign len_sat = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    assign len_post = (seg_idx_q >= LenFirstIdx && seg_idx_q < PadIdx) ? len_sat : len_cnt_q;

    // One search serves both the first segment in IDLE and the successor in SEG.
    assign sel_mask = (state_q == StIdle) ? MAX_SEG'(seg_en) : MAX_SEG'(en_q);
    assign sel_from = (state_q == StIdle) ? -1 : int'(seg_idx_q);
    assign nxt      = next_seg(sel_mask, sel_from);

    always_comb begin
        state_d     = state_q;
        seg_idx_d   = seg_idx_q;
        en_d        = en_q;
        len_cnt_d   = len_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        frame_len_d = frame_len_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_start && nxt.valid) begin
                    en_d      = seg_en;
                    seg_idx_d = SegW'(nxt.idx);
                    len_cnt_d = '0;
                    state_d   = StSeg;
                end
            end
            StSeg: begin
                len_cnt_d = len_post;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StGap;
                end else if (seg_done[seg_idx_q]) begin
                    if (nxt.valid && nxt.idx == PadIdx3 && len_post < MinLen) begin
                        seg_idx_d = SegW'(nxt.idx);
                        state_d   = StPad;
                    end else if (nxt.valid) begin
                        seg_idx_d = SegW'(nxt.idx);
                    end else begin
                        done_d      = 1'b1;
                        frame_len_d = len_post;
                        state_d     = StGap;
                    end
                end
            end
            StPad: begin
                len_cnt_d = len_sat;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StGap;
                end else if (len_sat >= MinLen) begin
                    state_d = StSeg;
                end
            end
            StGap: begin
                if (gap_cnt_q == IfgLast) begin
                    gap_cnt_d = '0;
                    state_d   = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= StIdle;
            seg_idx_q   <= '0;
            en_q        <= '0;
            len_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            frame_len_q <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            seg_idx_q   <= seg_idx_d;
            en_q        <= en_d;
            len_cnt_q   <= len_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            frame_len_q <= frame_len_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    always_comb begin
        data_valid = 1'b0;
        data_out   = '0;
        seg_active = '0;
        pad_active = 1'b0;
        if (state_q == StSeg) begin
            data_valid            = 1'b1;
            data_out              = seg_data[seg_idx_q*DATA_W +: DATA_W];
            seg_active[seg_idx_q] = 1'b1;
        end else if (state_q == StPad) begin
            data_valid = 1'b1;
            pad_active = 1'b1;
        end
    end

    assign busy             = (state_q != StIdle);
    assign tx_frame_done    = done_q;
    assign tx_frame_aborted = aborted_q;
    assign frame_len        = frame_len_q;

endmodule

// File: tb/tb_eth_tx_frame_seq.sv
// Randomised bench for eth_tx_frame_seq against a beat-list reference model.
module tb_eth_tx_frame_seq;

    localparam int NSEG = 4;
    localparam int IFG  = 12;
    localparam int MINL = 60;

    logic        aclk = 1'b0;
    logic        areset;
    logic        frame_start;
    logic [3:0]  seg_en;
    logic [3:0]  seg_done;
    logic [31:0] seg_data;
    logic        abort;
    logic [3:0]  seg_active;
    logic        pad_active;
    logic        data_valid;
    logic [7:0]  data_out;
    logic        busy;
    logic        tx_frame_done;
    logic        tx_frame_aborted;
    logic [15:0] frame_len;

    eth_tx_frame_seq dut (
        .aclk             (aclk),
        .areset           (areset),
        .frame_start      (frame_start),
        .seg_en           (seg_en),
        .seg_done         (seg_done),
        .seg_data         (seg_data),
        .abort            (abort),
        .seg_active       (seg_active),
        .pad_active       (pad_active),
        .data_valid       (data_valid),
        .data_out         (data_out),
        .busy             (busy),
        .tx_frame_done    (tx_frame_done),
        .tx_frame_aborted (tx_frame_aborted),
        .frame_len        (frame_len)
    );

    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Segment sources: byte k of segment i is seg_base[i] + 3*k.
    int         seg_len [NSEG];
    logic [7:0] seg_base[NSEG];
    int         ptr     [NSEG];
    logic       src_clr;

    always_comb begin
        seg_data = '0;
        seg_done = '0;
        for (int i = 0; i < NSEG; i++) begin
            seg_data[i*8 +: 8] = seg_base[i] + 8'(ptr[i] * 3);
            seg_done[i]        = (ptr[i] == seg_len[i] - 1);
        end
    end

    always @(posedge aclk) begin
        for (int i = 0; i < NSEG; i++) begin
            if (src_clr) ptr[i] <= 0;
            else if (seg_active[i]) ptr[i] <= ptr[i] + 1;
        end
    end

    typedef struct packed {
        logic       v;
        logic       pad;
        logic [3:0] act;
        logic [7:0] d;
    } beat_t;

    beat_t exp_q[$];
    int    last_len = 0;

    // Reference: enabled segments in order; pad to MINL counted bytes only when the FCS
    // segment follows an earlier segment; segments 1..2 are counted.
    function automatic void build_frame(input logic [3:0] mask, output int counted);
        bit first;
        beat_t b;
        exp_q.delete();
        counted = 0;
        first   = 1'b1;
        for (int s = 0; s < NSEG; s++) begin
            if (mask[s]) begin
                if (s == 3 && !first) begin
                    while (counted < MINL) begin
                        b = '{v: 1'b1, pad: 1'b1, act: 4'b0, d: 8'h00};
                        exp_q.push_back(b);
                        counted++;
                    end
                end
                for (int k = 0; k < seg_len[s]; k++) begin
                    b = '{v: 1'b1, pad: 1'b0, act: 4'(1 << s), d: seg_base[s] + 8'(k * 3)};
                    exp_q.push_back(b);
                    if (s >= 1 && s < 3) counted++;
                end
                first = 1'b0;
            end
        end
    endfunction

    task automatic set_lens(input int l0, input int l1, input int l2, input int l3);
        seg_len[0] = l0;
        seg_len[1] = l1;
        seg_len[2] = l2;
        seg_len[3] = l3;
        for (int i = 0; i < NSEG; i++) seg_base[i] = 8'($urandom);
    endtask

    task automatic run_frame(input logic [3:0] mask, input int abort_at, input int reset_at,
                             input bit poke);
        int counted;
        int gap;
        bit aborted;
        bit vlow_bad;
        build_frame(mask, counted);
        aborted = 1'b0;
        @(negedge aclk);
        src_clr     = 1'b1;
        seg_en      = mask;
        frame_start = 1'b1;
        @(negedge aclk);
        frame_start = 1'b0;
        src_clr     = 1'b0;
        seg_en      = 4'($urandom);
        for (int n = 0; n < exp_q.size(); n++) begin
            check_eq($sformatf("beat%0d", n),
                     32'({data_valid, pad_active, seg_active, data_out}), 32'(exp_q[n]));
            frame_start = poke && (n == 3);
            if (n == reset_at) begin
                frame_start = 1'b0;
                areset      = 1'b1;
                @(negedge aclk);
                areset = 1'b0;
                check_eq("rst_valid", 32'(data_valid), 32'd0);
                check_eq("rst_busy", 32'(busy), 32'd0);
                check_eq("rst_done", 32'(tx_frame_done), 32'd0);
                check_eq("rst_aborted", 32'(tx_frame_aborted), 32'd0);
                check_eq("rst_frame_len", 32'(frame_len), 32'd0);
                last_len = 0;
                return;
            end
            if (n == abort_at) begin
                abort = 1'b1;
                @(negedge aclk);
                abort       = 1'b0;
                frame_start = 1'b0;
                aborted     = 1'b1;
                break;
            end
            @(negedge aclk);
        end
        check_eq("end_valid", 32'(data_valid), 32'd0);
        check_eq("end_done", 32'(tx_frame_done), 32'(!aborted));
        check_eq("end_aborted", 32'(tx_frame_aborted), 32'(aborted));
        if (!aborted) last_len = counted;
        check_eq("frame_len", 32'(frame_len), 32'(last_len));
        gap      = 0;
        vlow_bad = 1'b0;
        while (busy && gap < 100) begin
            if (data_valid) vlow_bad = 1'b1;
            frame_start = poke && (gap == 5);
            gap++;
            @(negedge aclk);
        end
        frame_start = 1'b0;
        check_eq("gap_len", 32'(gap), 32'(IFG));
        check_eq("gap_valid_low", 32'(vlow_bad), 32'd0);
        @(negedge aclk);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_pulse", 32'({tx_frame_done, tx_frame_aborted}), 32'd0);
    endtask

    initial begin
        areset      = 1'b1;
        frame_start = 1'b0;
        abort       = 1'b0;
        seg_en      = '0;
        src_clr     = 1'b1;
        set_lens(8, 14, 46, 4);
        repeat (3) @(negedge aclk);
        check_eq("reset_outs",
                 32'({data_valid, pad_active, seg_active, data_out, busy, tx_frame_done,
                      tx_frame_aborted}), 32'd0);
        check_eq("reset_frame_len", 32'(frame_len), 32'd0);
        areset  = 1'b0;
        src_clr = 1'b0;

        @(negedge aclk);
        seg_en      = 4'b0000;
        frame_start = 1'b1;
        @(negedge aclk);
        frame_start = 1'b0;
        check_eq("mask0_busy", 32'(busy), 32'd0);
        check_eq("mask0_valid", 32'(data_valid), 32'd0);

        set_lens(8, 14, 46, 4);
        run_frame(4'b1111, -1, -1, 1'b1);
        set_lens(8, 14, 10, 4);
        run_frame(4'b1111, -1, -1, 1'b0);
        set_lens(8, 14, 30, 4);
        run_frame(4'b1011, -1, -1, 1'b0);
        set_lens(8, 14, 55, 4);
        run_frame(4'b1111, -1, -1, 1'b0);
        set_lens(8, 14, 46, 4);
        run_frame(4'b1111, 12, -1, 1'b0);
        set_lens(8, 14, 10, 4);
        run_frame(4'b1111, -1, 37, 1'b0);
        set_lens(8, 14, 46, 4);
        run_frame(4'b1111, -1, -1, 1'b0);

        for (int f = 0; f < 25; f++) begin
            int ab;
            set_lens($urandom_range(1, 10), $urandom_range(1, 20), $urandom_range(1, 60),
                     $urandom_range(1, 6));
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 20) : -1;
            run_frame(4'($urandom_range(1, 15)), ab, -1, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
